// File: rtl/dcache_axi_arb.sv
// dcache_axi_arb: two-port arbiter in front of the data-cache AXI bridge.
// Port 0 = refill/writeback, port 1 = uncached/IO.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   inportN_*  : requester N request/write-data in, accept and routed
//                b/r responses out (N = 0,1)
//   outport_*  : single request port toward the bridge plus the bridge's
//                b/r response channels
// Write grants are held for the whole burst. Responses are steered back
// by in-order source FIFOs (one for reads, one for writes).
//
// Build option: DCACHE_ARB_FIXED_PRIO_EN makes port 0 win whenever it is
// eligible; otherwise arbitration is round-robin.
module dcache_axi_arb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        inport0_valid_i,
  input  logic        inport0_write_i,
  input  logic [31:0] inport0_addr_i,
  input  logic [3:0]  inport0_id_i,
  input  logic [7:0]  inport0_len_i,
  input  logic [1:0]  inport0_burst_i,
  input  logic [31:0] inport0_wdata_i,
  input  logic [3:0]  inport0_wstrb_i,
  input  logic        inport0_bready_i,
  input  logic        inport0_rready_i,
  output logic        inport0_accept_o,
  output logic        inport0_bvalid_o,
  output logic [1:0]  inport0_bresp_o,
  output logic [3:0]  inport0_bid_o,
  output logic        inport0_rvalid_o,
  output logic [31:0] inport0_rdata_o,
  output logic [1:0]  inport0_rresp_o,
  output logic [3:0]  inport0_rid_o,
  output logic        inport0_rlast_o,

  input  logic        inport1_valid_i,
  input  logic        inport1_write_i,
  input  logic [31:0] inport1_addr_i,
  input  logic [3:0]  inport1_id_i,
  input  logic [7:0]  inport1_len_i,
  input  logic [1:0]  inport1_burst_i,
  input  logic [31:0] inport1_wdata_i,
  input  logic [3:0]  inport1_wstrb_i,
  input  logic        inport1_bready_i,
  input  logic        inport1_rready_i,
  output logic        inport1_accept_o,
  output logic        inport1_bvalid_o,
  output logic [1:0]  inport1_bresp_o,
  output logic [3:0]  inport1_bid_o,
  output logic        inport1_rvalid_o,
  output logic [31:0] inport1_rdata_o,
  output logic [1:0]  inport1_rresp_o,
  output logic [3:0]  inport1_rid_o,
  output logic        inport1_rlast_o,

  output logic        outport_valid_o,
  output logic        outport_write_o,
  output logic [31:0] outport_addr_o,
  output logic [3:0]  outport_id_o,
  output logic [7:0]  outport_len_o,
  output logic [1:0]  outport_burst_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_accept_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q;
  logic        grant_q;
  logic        rr_last_q;
  logic        first_q;
  logic [8:0]  beat_cnt_q;

  // Source FIFOs: one bit per entry = issuing port.
  logic [FIFO_DEPTH-1:0] rf_mem_q, wf_mem_q;
  logic [AW:0] rf_wr_q, rf_rd_q, wf_wr_q, wf_rd_q;
  logic rf_full, rf_empty, rf_head, rf_push, rf_pop;
  logic wf_full, wf_empty, wf_head, wf_push, wf_pop;

  assign rf_empty = (rf_wr_q == rf_rd_q);
  assign wf_empty = (wf_wr_q == wf_rd_q);
  assign rf_full  = (rf_wr_q[AW] != rf_rd_q[AW]) &&
                    (rf_wr_q[AW-1:0] == rf_rd_q[AW-1:0]);
  assign wf_full  = (wf_wr_q[AW] != wf_rd_q[AW]) &&
                    (wf_wr_q[AW-1:0] == wf_rd_q[AW-1:0]);
  assign rf_head  = rf_mem_q[rf_rd_q[AW-1:0]];
  assign wf_head  = wf_mem_q[wf_rd_q[AW-1:0]];

  // Arbitration
  logic elig0, elig1, any_elig, win, win_write;
  logic [7:0] win_len;

  assign elig0 = inport0_valid_i &
                 ~(inport0_write_i ? wf_full : rf_full);
  assign elig1 = inport1_valid_i &
                 ~(inport1_write_i ? wf_full : rf_full);
  assign any_elig = elig0 | elig1;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign win = ~elig0;
`else
  // Port other than the last winner gets first refusal.
  logic pref, pref_elig;
  assign pref      = ~rr_last_q;
  assign pref_elig = pref ? elig1 : elig0;
  assign win       = pref_elig ? pref : ~pref;
`endif

  assign win_write = win ? inport1_write_i : inport0_write_i;
  assign win_len   = win ? inport1_len_i : inport0_len_i;

  // Request mux (zero outside ACTIVE)
  logic active, fire;
  assign active = (state_q == ACTIVE);

  assign outport_valid_o = active &
    (grant_q ? inport1_valid_i : inport0_valid_i);
  assign outport_write_o = active &
    (grant_q ? inport1_write_i : inport0_write_i);
  assign outport_addr_o  = active ?
    (grant_q ? inport1_addr_i : inport0_addr_i) : '0;
  assign outport_id_o    = active ?
    (grant_q ? inport1_id_i : inport0_id_i) : '0;
  assign outport_len_o   = active ?
    (grant_q ? inport1_len_i : inport0_len_i) : '0;
  assign outport_burst_o = active ?
    (grant_q ? inport1_burst_i : inport0_burst_i) : '0;
  assign outport_wdata_o = active ?
    (grant_q ? inport1_wdata_i : inport0_wdata_i) : '0;
  assign outport_wstrb_o = active ?
    (grant_q ? inport1_wstrb_i : inport0_wstrb_i) : '0;

  assign fire = outport_valid_o & outport_accept_i;
  assign inport0_accept_o = fire & ~grant_q;
  assign inport1_accept_o = fire & grant_q;

  // First accept of a grant records the source for its response.
  assign rf_push = fire & first_q & ~outport_write_o;
  assign wf_push = fire & first_q & outport_write_o;

  // Read response routing
  logic rsel0, rsel1;
  assign rsel0 = ~rf_empty & ~rf_head;
  assign rsel1 = ~rf_empty & rf_head;

  assign outport_rready_o = (rsel0 & inport0_rready_i) |
                            (rsel1 & inport1_rready_i);
  assign rf_pop = outport_rvalid_i & outport_rready_o & outport_rlast_i;

  assign inport0_rvalid_o = rsel0 & outport_rvalid_i;
  assign inport0_rdata_o  = rsel0 ? outport_rdata_i : '0;
  assign inport0_rresp_o  = rsel0 ? outport_rresp_i : '0;
  assign inport0_rid_o    = rsel0 ? outport_rid_i : '0;
  assign inport0_rlast_o  = rsel0 & outport_rlast_i;
  assign inport1_rvalid_o = rsel1 & outport_rvalid_i;
  assign inport1_rdata_o  = rsel1 ? outport_rdata_i : '0;
  assign inport1_rresp_o  = rsel1 ? outport_rresp_i : '0;
  assign inport1_rid_o    = rsel1 ? outport_rid_i : '0;
  assign inport1_rlast_o  = rsel1 & outport_rlast_i;

  // Write response routing
  logic bsel0, bsel1;
  assign bsel0 = ~wf_empty & ~wf_head;
  assign bsel1 = ~wf_empty & wf_head;

  assign outport_bready_o = (bsel0 & inport0_bready_i) |
                            (bsel1 & inport1_bready_i);
  assign wf_pop = outport_bvalid_i & outport_bready_o;

  assign inport0_bvalid_o = bsel0 & outport_bvalid_i;
  assign inport0_bresp_o  = bsel0 ? outport_bresp_i : '0;
  assign inport0_bid_o    = bsel0 ? outport_bid_i : '0;
  assign inport1_bvalid_o = bsel1 & outport_bvalid_i;
  assign inport1_bresp_o  = bsel1 ? outport_bresp_i : '0;
  assign inport1_bid_o    = bsel1 ? outport_bid_i : '0;

  // Grant FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      rr_last_q  <= 1'b0;
`else
      rr_last_q  <= 1'b1;
`endif
      first_q    <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_elig) begin
            grant_q    <= win;
            beat_cnt_q <= win_write ?
                          ({1'b0, win_len} + 9'd1) : 9'd1;
            first_q    <= 1'b1;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (fire) begin
            first_q    <= 1'b0;
            beat_cnt_q <= beat_cnt_q - 9'd1;
            if (beat_cnt_q == 9'd1) begin
`ifndef DCACHE_ARB_FIXED_PRIO_EN
              rr_last_q <= grant_q;
`endif
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Source FIFO pointers/storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_mem_q <= '0;
      wf_mem_q <= '0;
      rf_wr_q  <= '0;
      rf_rd_q  <= '0;
      wf_wr_q  <= '0;
      wf_rd_q  <= '0;
    end else begin
      if (rf_push) begin
        rf_mem_q[rf_wr_q[AW-1:0]] <= grant_q;
        rf_wr_q <= rf_wr_q + PTR_ONE;
      end
      if (rf_pop) rf_rd_q <= rf_rd_q + PTR_ONE;
      if (wf_push) begin
        wf_mem_q[wf_wr_q[AW-1:0]] <= grant_q;
        wf_wr_q <= wf_wr_q + PTR_ONE;
      end
      if (wf_pop) wf_rd_q <= wf_rd_q + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_dcache_axi_arb.sv
// tb_dcache_axi_arb: scoreboard bench for dcache_axi_arb.
// Expected accepts/responses are queued by stimulus, checked by a monitor.
module tb_dcache_axi_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_write [2];
  logic [31:0] in_addr  [2];
  logic [3:0]  in_id    [2];
  logic [7:0]  in_len   [2];
  logic [1:0]  in_burst [2];
  logic [31:0] in_wdata [2];
  logic [3:0]  in_wstrb [2];
  logic        in_bready[2];
  logic        in_rready[2];

  logic        acc   [2];
  logic        bvalid[2];
  logic [1:0]  bresp [2];
  logic [3:0]  bid   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic [1:0]  rresp [2];
  logic [3:0]  rid   [2];
  logic        rlast [2];

  logic        o_valid, o_write;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_id, o_wstrb;
  logic [7:0]  o_len;
  logic [1:0]  o_burst;
  logic        o_accept = 1'b1;
  logic        o_bvalid = 1'b0;
  logic [1:0]  o_bresp = 2'b00;
  logic [3:0]  o_bid = 4'h0;
  logic        o_bready;
  logic        o_rvalid = 1'b0;
  logic [31:0] o_rdata = '0;
  logic [1:0]  o_rresp = 2'b00;
  logic [3:0]  o_rid = 4'h0;
  logic        o_rlast = 1'b0;
  logic        o_rready;

  dcache_axi_arb #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .inport0_valid_i(in_valid[0]), .inport0_write_i(in_write[0]),
    .inport0_addr_i(in_addr[0]), .inport0_id_i(in_id[0]),
    .inport0_len_i(in_len[0]), .inport0_burst_i(in_burst[0]),
    .inport0_wdata_i(in_wdata[0]), .inport0_wstrb_i(in_wstrb[0]),
    .inport0_bready_i(in_bready[0]), .inport0_rready_i(in_rready[0]),
    .inport0_accept_o(acc[0]),
    .inport0_bvalid_o(bvalid[0]), .inport0_bresp_o(bresp[0]),
    .inport0_bid_o(bid[0]),
    .inport0_rvalid_o(rvalid[0]), .inport0_rdata_o(rdata[0]),
    .inport0_rresp_o(rresp[0]), .inport0_rid_o(rid[0]),
    .inport0_rlast_o(rlast[0]),
    .inport1_valid_i(in_valid[1]), .inport1_write_i(in_write[1]),
    .inport1_addr_i(in_addr[1]), .inport1_id_i(in_id[1]),
    .inport1_len_i(in_len[1]), .inport1_burst_i(in_burst[1]),
    .inport1_wdata_i(in_wdata[1]), .inport1_wstrb_i(in_wstrb[1]),
    .inport1_bready_i(in_bready[1]), .inport1_rready_i(in_rready[1]),
    .inport1_accept_o(acc[1]),
    .inport1_bvalid_o(bvalid[1]), .inport1_bresp_o(bresp[1]),
    .inport1_bid_o(bid[1]),
    .inport1_rvalid_o(rvalid[1]), .inport1_rdata_o(rdata[1]),
    .inport1_rresp_o(rresp[1]), .inport1_rid_o(rid[1]),
    .inport1_rlast_o(rlast[1]),
    .outport_valid_o(o_valid), .outport_write_o(o_write),
    .outport_addr_o(o_addr), .outport_id_o(o_id),
    .outport_len_o(o_len), .outport_burst_o(o_burst),
    .outport_wdata_o(o_wdata), .outport_wstrb_o(o_wstrb),
    .outport_accept_i(o_accept),
    .outport_bvalid_i(o_bvalid), .outport_bresp_i(o_bresp),
    .outport_bid_i(o_bid), .outport_bready_o(o_bready),
    .outport_rvalid_i(o_rvalid), .outport_rdata_i(o_rdata),
    .outport_rresp_i(o_rresp), .outport_rid_i(o_rid),
    .outport_rlast_i(o_rlast), .outport_rready_o(o_rready)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
  } acc_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [3:0]  id;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_r[$];
  rsp_t exp_b[$];

  int cyc = 0;
  int fire_cyc[2];
  int fire_cnt[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every observed handshake against the queues.
  always @(negedge clk) begin : mon
    acc_t e;
    rsp_t r;
    logic p;
    if (!rst) begin
      if (o_valid && o_accept) begin
        p = acc[1];
        check("acc_onehot", acc[0] ^ acc[1], 1);
        fire_cyc[p] = cyc;
        fire_cnt[p] = fire_cnt[p] + 1;
        if (exp_acc.size() == 0) check("acc_unexpected", 1, 0);
        else begin
          e = exp_acc.pop_front();
          check("acc_port", p, e.port);
          check("acc_addr", o_addr, e.addr);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rvalid[i] && in_rready[i]) begin
          check("r_other_idle", rvalid[1-i], 0);
          if (exp_r.size() == 0) check("r_unexpected", 1, 0);
          else begin
            r = exp_r.pop_front();
            check("r_port", i, r.port);
            check("r_data", rdata[i], r.data);
            check("r_id", rid[i], r.id);
          end
        end
        if (bvalid[i] && in_bready[i]) begin
          check("b_other_idle", bvalid[1-i], 0);
          if (exp_b.size() == 0) check("b_unexpected", 1, 0);
          else begin
            r = exp_b.pop_front();
            check("b_port", i, r.port);
            check("b_resp", bresp[i], r.data);
            check("b_id", bid[i], r.id);
          end
        end
      end
    end
  end

  task automatic req(input int p, input logic w,
                     input logic [31:0] a, input logic [7:0] l);
    int beats;
    int n;
    int guard;
    beats = w ? int'(l) + 1 : 1;
    n = 0;
    guard = 0;
    in_write[p] = w;
    in_addr[p]  = a;
    in_len[p]   = l;
    in_id[p]    = 4'(p + 1);
    in_wdata[p] = a;
    in_wstrb[p] = 4'hf;
    in_valid[p] = 1'b1;
    while (n < beats && guard < 300) begin
      @(negedge clk);
      guard++;
      if (acc[p]) begin
        n++;
        @(posedge clk);
        #1;
        in_wdata[p] = a + 32'(n);
      end
    end
    if (n < beats) check("req_timeout", n, beats);
    in_valid[p] = 1'b0;
  endtask

  task automatic rsp_r(input logic [31:0] d, input logic [3:0] id);
    int guard;
    guard = 0;
    o_rvalid = 1'b1;
    o_rdata  = d;
    o_rid    = id;
    o_rlast  = 1'b1;
    @(negedge clk);
    while (!o_rready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!o_rready) check("r_timeout", 0, 1);
    @(posedge clk);
    #1;
    o_rvalid = 1'b0;
    o_rlast  = 1'b0;
  endtask

  task automatic rsp_b(input logic [1:0] rs, input logic [3:0] id);
    int guard;
    guard = 0;
    o_bvalid = 1'b1;
    o_bresp  = rs;
    o_bid    = id;
    @(negedge clk);
    while (!o_bready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!o_bready) check("b_timeout", 0, 1);
    @(posedge clk);
    #1;
    o_bvalid = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int guard;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;  in_write[i] = 1'b0;
      in_addr[i]  = '0;    in_id[i]    = '0;
      in_len[i]   = '0;    in_burst[i] = 2'b01;
      in_wdata[i] = '0;    in_wstrb[i] = '0;
      in_bready[i] = 1'b1; in_rready[i] = 1'b1;
      fire_cyc[i] = 0;     fire_cnt[i] = 0;
    end

    // Reset state
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_acc0", acc[0], 0);
    check("rst_acc1", acc[1], 0);
    check("rst_rready", o_rready, 0);
    check("rst_bready", o_bready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: simultaneous reads, port 0 first, gap of 2 cycles
    exp_acc.push_back(acc_t'{1'b0, 32'h1000});
    exp_acc.push_back(acc_t'{1'b1, 32'h2000});
    fork
      req(0, 1'b0, 32'h1000, 8'd0);
      req(1, 1'b0, 32'h2000, 8'd0);
    join
    check("rr_gap", fire_cyc[1] - fire_cyc[0], 2);
    exp_r.push_back(rsp_t'{1'b0, 32'hA0A0_0000, 4'd3});
    rsp_r(32'hA0A0_0000, 4'd3);
    exp_r.push_back(rsp_t'{1'b1, 32'hB1B1_0001, 4'd3});
    rsp_r(32'hB1B1_0001, 4'd3);

    // 2: port 0 write burst locks out pending port 1 read
    for (int b = 0; b < 4; b++)
      exp_acc.push_back(acc_t'{1'b0, 32'h3000});
    exp_acc.push_back(acc_t'{1'b1, 32'h4000});
    fork
      req(0, 1'b1, 32'h3000, 8'd3);
      req(1, 1'b0, 32'h4000, 8'd0);
    join
    exp_b.push_back(rsp_t'{1'b0, 32'd1, 4'd5});
    rsp_b(2'b01, 4'd5);
    exp_r.push_back(rsp_t'{1'b1, 32'h0000_4444, 4'd2});
    rsp_r(32'h0000_4444, 4'd2);

    // 3: port 1 fills the read FIFO, port 0 write still served
    base = fire_cnt[1];
    for (int k = 0; k < 4; k++) begin
      exp_acc.push_back(acc_t'{1'b1, 32'h5000 + 32'(k)});
      req(1, 1'b0, 32'h5000 + 32'(k), 8'd0);
    end
    exp_acc.push_back(acc_t'{1'b0, 32'h6000});
    exp_acc.push_back(acc_t'{1'b0, 32'h6000});
    exp_acc.push_back(acc_t'{1'b1, 32'h5004});
    fork
      req(0, 1'b1, 32'h6000, 8'd1);
      req(1, 1'b0, 32'h5004, 8'd0);
      begin
        repeat (12) @(posedge clk);
        #1;
        check("full_blocks_p1", fire_cnt[1] - base, 4);
        exp_r.push_back(rsp_t'{1'b1, 32'h0000_5000, 4'd2});
        rsp_r(32'h0000_5000, 4'd2);
      end
    join
    for (int k = 1; k < 5; k++) begin
      exp_r.push_back(rsp_t'{1'b1, 32'h0000_5000 + 32'(k), 4'd2});
      rsp_r(32'h0000_5000 + 32'(k), 4'd2);
    end
    exp_b.push_back(rsp_t'{1'b0, 32'd0, 4'd1});
    rsp_b(2'b00, 4'd1);

    // 4: bridge rvalid/bvalid with empty FIFOs
    o_rvalid = 1'b1;
    o_rlast  = 1'b1;
    o_bvalid = 1'b1;
    @(negedge clk);
    check("empty_rready", o_rready, 0);
    check("empty_rvalid", {rvalid[1], rvalid[0]}, 0);
    check("empty_bready", o_bready, 0);
    check("empty_bvalid", {bvalid[1], bvalid[0]}, 0);
    @(posedge clk);
    #1;
    o_rvalid = 1'b0;
    o_rlast  = 1'b0;
    o_bvalid = 1'b0;

    // 5: reset during beat 2 of a len=7 write
    exp_acc.push_back(acc_t'{1'b1, 32'h7000});
    in_write[1] = 1'b1;
    in_addr[1]  = 32'h7000;
    in_len[1]   = 8'd7;
    in_wdata[1] = 32'h7000;
    in_wstrb[1] = 4'hf;
    in_valid[1] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!acc[1] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rst_burst_start", acc[1], 1);
    @(posedge clk);
    #1;
    in_wdata[1] = 32'h7001;
    check("beat2_valid", o_valid, 1);
    o_bvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_write", o_write, 0);
    check("arst_addr", o_addr, 0);
    check("arst_len", o_len, 0);
    check("arst_wdata", o_wdata, 0);
    check("arst_acc1", acc[1], 0);
    check("arst_bready", o_bready, 0);
    check("arst_bvalid1", bvalid[1], 0);
    in_valid[1] = 1'b0;
    exp_acc.delete();
    exp_r.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("discard_bvalid1", bvalid[1], 0);
    check("discard_bready", o_bready, 0);
    @(posedge clk);
    #1;
    o_bvalid = 1'b0;
    exp_acc.push_back(acc_t'{1'b0, 32'h8000});
    exp_acc.push_back(acc_t'{1'b1, 32'h9000});
    fork
      req(0, 1'b0, 32'h8000, 8'd0);
      req(1, 1'b0, 32'h9000, 8'd0);
    join
    exp_r.push_back(rsp_t'{1'b0, 32'h0000_8888, 4'd1});
    rsp_r(32'h0000_8888, 4'd1);
    exp_r.push_back(rsp_t'{1'b1, 32'h0000_9999, 4'd2});
    rsp_r(32'h0000_9999, 4'd2);

    // 6: port 0 back-to-back while port 1 waits
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    exp_acc.push_back(acc_t'{1'b0, 32'hA000});
    exp_acc.push_back(acc_t'{1'b0, 32'hA001});
    exp_acc.push_back(acc_t'{1'b0, 32'hA002});
    exp_acc.push_back(acc_t'{1'b1, 32'hB000});
`else
    exp_acc.push_back(acc_t'{1'b0, 32'hA000});
    exp_acc.push_back(acc_t'{1'b1, 32'hB000});
    exp_acc.push_back(acc_t'{1'b0, 32'hA001});
    exp_acc.push_back(acc_t'{1'b0, 32'hA002});
`endif
    fork
      begin
        for (int k = 0; k < 3; k++)
          req(0, 1'b0, 32'hA000 + 32'(k), 8'd0);
      end
      req(1, 1'b0, 32'hB000, 8'd0);
    join
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++)
      exp_r.push_back(rsp_t'{1'b0, 32'hC000 + 32'(k), 4'd1});
    exp_r.push_back(rsp_t'{1'b1, 32'hC003, 4'd1});
`else
    exp_r.push_back(rsp_t'{1'b0, 32'hC000, 4'd1});
    exp_r.push_back(rsp_t'{1'b1, 32'hC001, 4'd1});
    exp_r.push_back(rsp_t'{1'b0, 32'hC002, 4'd1});
    exp_r.push_back(rsp_t'{1'b0, 32'hC003, 4'd1});
`endif
    for (int k = 0; k < 4; k++)
      rsp_r(32'hC000 + 32'(k), 4'd1);

    repeat (3) @(posedge clk);
    check("acc_q_drained", exp_acc.size(), 0);
    check("r_q_drained", exp_r.size(), 0);
    check("b_q_drained", exp_b.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
